axi_rd_fifo_slave: RTL and testbench

Parametrised AXI4 read-channel slave that answers read bursts from one of NUM_FIFO first-word-fall-through output FIFOs. The FIFO is selected by address bits. Generalises the single-FIFO read FSM in several ways: it carries the data path, handles out-of-range selects, tolerates a FIFO running empty mid-burst, and has an optional empty-stall timeout. It sits between the AXI interconnect slave port s0 and the per-channel output FIFO bank.

---
 rtl/axi_rd_fifo_slave.sv | 193 +++++++++++++++++++
 tb/tb_axi_rd_fifo_slave.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_fifo_slave.sv
// -----------------------------------------------------------------------------
// axi_rd_fifo_slave
//
// AXI4 read-channel slave that serves read bursts from one of NUM_FIFO
// first-word-fall-through output FIFOs. The FIFO is selected by the field
// araddr[SEL_LSB +: SEL_W] of the burst start address. Only one transaction
// is outstanding at a time.
//
// Error handling:
//  - A select value >= NUM_FIFO turns the whole burst into SLVERR beats with
//    zero data. No FIFO is ever popped for those beats.
//  - With TIMEOUT > 0, a FIFO that stays empty for TIMEOUT consecutive cycles
//    switches the rest of the burst to SLVERR beats. The current beat is
//    included. The burst still returns all arlen+1 beats.
//
// Ports:
//  clk, reset_n        clock, asynchronous active-low reset
//  axs_s0_ar*          AXI read address channel (arsize/arburst are ignored)
//  axs_s0_r*           AXI read data channel
//  out_fifo_data       FWFT heads, FIFO i at [i*DATA_W +: DATA_W]
//  out_fifo_empty      per-FIFO empty flags
//  out_fifo_pop        one-hot pop, asserted on the completing beat only
// -----------------------------------------------------------------------------
module axi_rd_fifo_slave #(
  parameter int ID_W     = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_FIFO = 4,
  parameter int SEL_W    = 2,
  parameter int SEL_LSB  = 12,
  parameter int TIMEOUT  = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ID_W-1:0]            axs_s0_arid,
  input  logic [ADDR_W-1:0]          axs_s0_araddr,
  input  logic [7:0]                 axs_s0_arlen,
  input  logic [2:0]                 axs_s0_arsize,
  input  logic [1:0]                 axs_s0_arburst,
  input  logic                       axs_s0_arvalid,
  output logic                       axs_s0_arready,
  output logic [ID_W-1:0]            axs_s0_rid,
  output logic [DATA_W-1:0]          axs_s0_rdata,
  output logic [1:0]                 axs_s0_rresp,
  output logic                       axs_s0_rlast,
  output logic                       axs_s0_rvalid,
  input  logic                       axs_s0_rready,
  input  logic [NUM_FIFO*DATA_W-1:0] out_fifo_data,
  input  logic [NUM_FIFO-1:0]        out_fifo_empty,
  output logic [NUM_FIFO-1:0]        out_fifo_pop
);

  localparam int              SEL_N      = 1 << SEL_W;
  localparam logic [SEL_W:0]  NUM_FIFO_W = (SEL_W + 1)'(NUM_FIFO);
  localparam logic [15:0]     TIMEOUT_W  = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   rid_reg, rid_next;
  logic [SEL_W-1:0]  sel_reg, sel_next;
  logic [7:0]        beats_left_reg, beats_left_next;
  logic              err_reg, err_next;
  logic [15:0]       stall_cnt_reg, stall_cnt_next;
  logic              pop_en;

  logic [SEL_W-1:0]  ar_sel;
  logic              unused_ar_fields;

  // Select values that have no FIFO behind them still need a legal array
  // slot. They read as permanently empty with zero data. The err flag keeps
  // these slots out of the data path anyway.
  logic [SEL_N-1:0]  empty_pad;
  logic [DATA_W-1:0] head_pad [SEL_N];

  assign ar_sel           = axs_s0_araddr[SEL_LSB +: SEL_W];
  assign unused_ar_fields = ^{axs_s0_arsize, axs_s0_arburst, axs_s0_araddr};

  generate
    for (genvar gi = 0; gi < SEL_N; gi++) begin : g_pad
      if (gi < NUM_FIFO) begin : g_real
        assign empty_pad[gi] = out_fifo_empty[gi];
        assign head_pad[gi]  = out_fifo_data[gi*DATA_W +: DATA_W];
      end else begin : g_void
        assign empty_pad[gi] = 1'b1;
        assign head_pad[gi]  = '0;
      end
    end
    for (genvar gi = 0; gi < NUM_FIFO; gi++) begin : g_pop
      assign out_fifo_pop[gi] = pop_en && (sel_reg == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_INIT;
      rid_reg        <= '0;
      sel_reg        <= '0;
      beats_left_reg <= '0;
      err_reg        <= 1'b0;
      stall_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      rid_reg        <= rid_next;
      sel_reg        <= sel_next;
      beats_left_reg <= beats_left_next;
      err_reg        <= err_next;
      stall_cnt_reg  <= stall_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    rid_next        = rid_reg;
    sel_next        = sel_reg;
    beats_left_next = beats_left_reg;
    err_next        = err_reg;
    stall_cnt_next  = stall_cnt_reg;
    axs_s0_arready  = 1'b0;
    axs_s0_rvalid   = 1'b0;
    axs_s0_rdata    = '0;
    axs_s0_rresp    = 2'b00;
    axs_s0_rlast    = 1'b0;
    axs_s0_rid      = '0;
    pop_en          = 1'b0;

    case (state_reg)
      ST_INIT: begin
        rid_next        = '0;
        sel_next        = '0;
        beats_left_next = '0;
        err_next        = 1'b0;
        stall_cnt_next  = '0;
        state_next      = ST_IDLE;
      end

      ST_IDLE: begin
        axs_s0_arready = 1'b1;
        if (axs_s0_arvalid) begin
          rid_next        = axs_s0_arid;
          sel_next        = ar_sel;
          beats_left_next = axs_s0_arlen;
          err_next        = ({1'b0, ar_sel} >= NUM_FIFO_W);
          stall_cnt_next  = '0;
          state_next      = ST_DATA;
        end
      end

      ST_DATA: begin
        axs_s0_rid = rid_reg;
        if (err_reg) begin
          axs_s0_rvalid = 1'b1;
          axs_s0_rresp  = 2'b10;
        end else begin
          axs_s0_rvalid = ~empty_pad[sel_reg];
          axs_s0_rdata  = head_pad[sel_reg];
        end
        axs_s0_rlast = axs_s0_rvalid && (beats_left_reg == 8'd0);

        if (axs_s0_rvalid && axs_s0_rready) begin
          pop_en = ~err_reg;
          if (beats_left_reg == 8'd0) begin
            state_next = ST_IDLE;
          end else begin
            beats_left_next = beats_left_reg - 8'd1;
          end
        end

        // err only rises on a cycle where rvalid is low, so a presented beat
        // never changes under the master.
        if (TIMEOUT > 0 && !err_reg) begin
          if (axs_s0_rvalid) begin
            stall_cnt_next = '0;
          end else begin
            stall_cnt_next = stall_cnt_reg + 16'd1;
            if (stall_cnt_next == TIMEOUT_W) begin
              err_next = 1'b1;
            end
          end
        end
      end

      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_rd_fifo_slave.sv
module tb_axi_rd_fifo_slave;

  localparam int NF = 3;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [3:0]      arid = '0;
  logic [31:0]     araddr = '0;
  logic [7:0]      arlen = '0;
  logic [2:0]      arsize = '0;
  logic [1:0]      arburst = '0;
  logic            arvalid = 1'b0;
  logic            arready;
  logic [3:0]      rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready = 1'b0;
  logic [NF*DW-1:0] out_fifo_data;
  logic [NF-1:0]   out_fifo_empty;
  logic [NF-1:0]   out_fifo_pop;

  axi_rd_fifo_slave #(
    .ID_W(4), .ADDR_W(32), .DATA_W(DW), .NUM_FIFO(NF),
    .SEL_W(2), .SEL_LSB(12), .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .axs_s0_arid(arid),
    .axs_s0_araddr(araddr),
    .axs_s0_arlen(arlen),
    .axs_s0_arsize(arsize),
    .axs_s0_arburst(arburst),
    .axs_s0_arvalid(arvalid),
    .axs_s0_arready(arready),
    .axs_s0_rid(rid),
    .axs_s0_rdata(rdata),
    .axs_s0_rresp(rresp),
    .axs_s0_rlast(rlast),
    .axs_s0_rvalid(rvalid),
    .axs_s0_rready(rready),
    .out_fifo_data(out_fifo_data),
    .out_fifo_empty(out_fifo_empty),
    .out_fifo_pop(out_fifo_pop)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO bank model
  logic [31:0] fmem [NF][64];
  int wr_ptr [NF] = '{0, 0, 0};
  int rd_ptr [NF] = '{0, 0, 0};

  always_comb begin
    out_fifo_empty = '0;
    out_fifo_data  = '0;
    for (int i = 0; i < NF; i++) begin
      out_fifo_empty[i]         = (rd_ptr[i] == wr_ptr[i]);
      out_fifo_data[i*DW +: DW] = fmem[i][rd_ptr[i] & 63];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NF; i++) begin
      if (out_fifo_pop[i]) rd_ptr[i] <= rd_ptr[i] + 1;
    end
  end

  task automatic push_word(input int f, input logic [31:0] w);
    fmem[f][wr_ptr[f] & 63] = w;
    wr_ptr[f] = wr_ptr[f] + 1;
  endtask

  // Scoreboard
  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
    logic [2:0]  pop;
  } exp_t;

  exp_t sb[$];
  int   hs_q[$];

  task automatic exp_push(input logic [31:0] d, input logic [1:0] r, input logic l,
                          input logic [3:0] id, input logic [2:0] p);
    exp_t e;
    e.data = d; e.resp = r; e.last = l; e.id = id; e.pop = p;
    sb.push_back(e);
  endtask

  // Beat monitor: compares every completed beat against the scoreboard,
  // checks rvalid stability and that pops only accompany beats.
  exp_t mon_e;
  bit   prev_wait = 1'b0;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_wait = 1'b0;
      end else begin
        if (prev_wait) begin
          total++;
          if (rvalid !== 1'b1) begin
            bad++;
            $display("FAIL rvalid_hold: rvalid=%b need 1 (cycle %0d)", rvalid, cyc);
          end
        end
        if (rvalid === 1'b1 && arready !== 1'b0) begin
          total++; bad++;
          $display("FAIL arready_in_data: arready=%b need 0 (cycle %0d)", arready, cyc);
        end
        if (rvalid === 1'b1 && rready === 1'b1) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_beat: data=%h resp=%b need no beat (cycle %0d)", rdata, rresp, cyc);
          end else begin
            mon_e = sb.pop_front();
            if (rdata !== mon_e.data || rresp !== mon_e.resp || rlast !== mon_e.last ||
                rid !== mon_e.id || out_fifo_pop !== mon_e.pop) begin
              bad++;
              $display("FAIL beat: got data=%h resp=%b last=%b id=%h pop=%b need data=%h resp=%b last=%b id=%h pop=%b (cycle %0d)",
                       rdata, rresp, rlast, rid, out_fifo_pop,
                       mon_e.data, mon_e.resp, mon_e.last, mon_e.id, mon_e.pop, cyc);
            end
          end
          hs_q.push_back(cyc);
        end else begin
          total++;
          if (out_fifo_pop !== 3'b000) begin
            bad++;
            $display("FAIL pop_no_beat: pop=%b need 000 (cycle %0d)", out_fifo_pop, cyc);
          end
        end
        prev_wait = (rvalid === 1'b1) && (rready !== 1'b1);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_ar(input logic [3:0] id, input logic [1:0] s, input logic [7:0] len,
                          output int hs_cyc);
    bit done;
    logic [31:0] a;
    a = $urandom;
    a[13:12] = s;
    arid = id; araddr = a; arlen = len; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1;
    done = 1'b0;
    hs_cyc = -1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (arready === 1'b1) begin
        hs_cyc = cyc;
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL ar_accept: arready never seen for id=%h", id);
    end
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 600 && !done; n++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_drain: %0d beats outstanding need 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (arready !== 1'b0 || rvalid !== 1'b0 || out_fifo_pop !== 3'b000 || rid !== 4'h0) begin
      bad++;
      $display("FAIL reset_outputs: arready=%b rvalid=%b pop=%b rid=%h need all 0",
               arready, rvalid, out_fifo_pop, rid);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (arready !== 1'b0) begin
      bad++;
      $display("FAIL init_cycle: arready=%b need 0", arready);
    end
    @(negedge clk);
    total++;
    if (arready !== 1'b1) begin
      bad++;
      $display("FAIL idle_after_init: arready=%b need 1", arready);
    end
  endtask

  task automatic test_single();
    int n;
    step();
    push_word(1, 32'hA5A5_0001);
    exp_push(32'hA5A5_0001, 2'b00, 1'b1, 4'd3, 3'b010);
    hs_q.delete();
    rready = 1'b1;
    issue_ar(4'd3, 2'd1, 8'd0, n);
    wait_drain("single");
    total++;
    if (hs_q.size() != 1 || hs_q[0] != n + 1) begin
      bad++;
      $display("FAIL single_latency: beats=%0d first=%0d need 1 beat at %0d",
               hs_q.size(), (hs_q.size() > 0) ? hs_q[0] : -1, n + 1);
    end
    @(negedge clk);
    total++;
    if (arready !== 1'b1) begin
      bad++;
      $display("FAIL single_rearm: arready=%b need 1 at N+2", arready);
    end
  endtask

  task automatic test_gap();
    int n, p0, pushed, empty_run;
    step();
    p0 = rd_ptr[2];
    push_word(2, 32'hC2C2_0000);
    push_word(2, 32'hC2C2_0001);
    for (int k = 0; k < 4; k++) begin
      exp_push(32'hC2C2_0000 + k, 2'b00, k == 3, 4'd9, 3'b100);
    end
    rready = 1'b1;
    issue_ar(4'd9, 2'd2, 8'd3, n);
    pushed = 2;
    empty_run = 0;
    for (int c = 0; c < 80 && sb.size() != 0; c++) begin
      rready = (c % 3) != 1;
      if (pushed == 2 && out_fifo_empty[2]) begin
        empty_run++;
        if (empty_run == 5) begin
          push_word(2, 32'hC2C2_0002);
          push_word(2, 32'hC2C2_0003);
          pushed = 4;
        end
      end
      step();
    end
    rready = 1'b1;
    wait_drain("gap");
    total++;
    if (rd_ptr[2] - p0 != 4) begin
      bad++;
      $display("FAIL gap_pops: pops=%0d need 4", rd_ptr[2] - p0);
    end
  endtask

  task automatic test_out_of_range();
    int n, p_sum0, p_sum1;
    step();
    p_sum0 = rd_ptr[0] + rd_ptr[1] + rd_ptr[2];
    for (int k = 0; k < 3; k++) begin
      exp_push(32'h0, 2'b10, k == 2, 4'd7, 3'b000);
    end
    rready = 1'b1;
    issue_ar(4'd7, 2'd3, 8'd2, n);
    wait_drain("oob");
    p_sum1 = rd_ptr[0] + rd_ptr[1] + rd_ptr[2];
    total++;
    if (p_sum1 != p_sum0) begin
      bad++;
      $display("FAIL oob_pops: pops=%0d need 0", p_sum1 - p_sum0);
    end
  endtask

  task automatic test_timeout();
    int n, p0;
    step();
    p0 = rd_ptr[0];
    push_word(0, 32'hB0B0_0001);
    exp_push(32'hB0B0_0001, 2'b00, 1'b0, 4'd4, 3'b001);
    for (int k = 1; k < 4; k++) begin
      exp_push(32'h0, 2'b10, k == 3, 4'd4, 3'b000);
    end
    hs_q.delete();
    rready = 1'b1;
    issue_ar(4'd4, 2'd0, 8'd3, n);
    wait_drain("timeout");
    total++;
    if (hs_q.size() != 4 || hs_q[0] != n + 1 || hs_q[1] != n + 10 ||
        hs_q[2] != n + 11 || hs_q[3] != n + 12) begin
      bad++;
      $display("FAIL timeout_timing: beats=%0d second=%0d need 4 beats, second at %0d",
               hs_q.size(), (hs_q.size() > 1) ? hs_q[1] : -1, n + 10);
    end
    total++;
    if (rd_ptr[0] - p0 != 1) begin
      bad++;
      $display("FAIL timeout_pops: pops=%0d need 1", rd_ptr[0] - p0);
    end
  endtask

  task automatic test_reset_mid_burst();
    int n, p0;
    step();
    for (int k = 0; k < 8; k++) push_word(1, 32'hD1D1_0000 + k);
    exp_push(32'hD1D1_0000, 2'b00, 1'b0, 4'd6, 3'b010);
    rready = 1'b1;
    issue_ar(4'd6, 2'd1, 8'd7, n);
    step();
    rready = 1'b0;
    @(negedge clk);
    total++;
    if (rvalid !== 1'b1) begin
      bad++;
      $display("FAIL mid_beat2_valid: rvalid=%b need 1", rvalid);
    end
    #1;
    p0 = rd_ptr[1];
    reset_n = 1'b0;
    #1;
    total++;
    if (arready !== 1'b0 || rvalid !== 1'b0 || out_fifo_pop !== 3'b000 ||
        rid !== 4'h0 || rdata !== 32'h0 || rlast !== 1'b0) begin
      bad++;
      $display("FAIL mid_async_clear: arready=%b rvalid=%b pop=%b rid=%h rdata=%h rlast=%b need all 0",
               arready, rvalid, out_fifo_pop, rid, rdata, rlast);
    end
    step();
    step();
    total++;
    if (rd_ptr[1] != p0 || sb.size() != 0) begin
      bad++;
      $display("FAIL mid_no_pop: pops=%0d pending=%0d need 0 and 0", rd_ptr[1] - p0, sb.size());
    end
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (arready !== 1'b0) begin
      bad++;
      $display("FAIL mid_init: arready=%b need 0", arready);
    end
    @(negedge clk);
    total++;
    if (arready !== 1'b1) begin
      bad++;
      $display("FAIL mid_idle: arready=%b need 1", arready);
    end
    step();
    for (int k = 1; k < 8; k++) begin
      exp_push(32'hD1D1_0000 + k, 2'b00, k == 7, 4'd10, 3'b010);
    end
    rready = 1'b1;
    issue_ar(4'd10, 2'd1, 8'd6, n);
    wait_drain("mid_new");
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    step();
    push_word(0, 32'hE0E0_0000);
    push_word(0, 32'hE0E0_0001);
    push_word(1, 32'hE1E1_0000);
    push_word(1, 32'hE1E1_0001);
    exp_push(32'hE0E0_0000, 2'b00, 1'b0, 4'd5, 3'b001);
    exp_push(32'hE0E0_0001, 2'b00, 1'b1, 4'd5, 3'b001);
    exp_push(32'hE1E1_0000, 2'b00, 1'b0, 4'd6, 3'b010);
    exp_push(32'hE1E1_0001, 2'b00, 1'b1, 4'd6, 3'b010);
    hs_q.delete();
    rready = 1'b1;
    issue_ar(4'd5, 2'd0, 8'd1, n1);
    issue_ar(4'd6, 2'd1, 8'd1, n2);
    wait_drain("b2b");
    total++;
    if (n2 != n1 + 3) begin
      bad++;
      $display("FAIL b2b_ar_gap: second AR at %0d need %0d", n2, n1 + 3);
    end
    total++;
    if (hs_q.size() != 4 || hs_q[1] != n1 + 2 || hs_q[2] != n2 + 1) begin
      bad++;
      $display("FAIL b2b_beats: beats=%0d need 4 with last of burst1 at %0d and first of burst2 at %0d",
               hs_q.size(), n1 + 2, n2 + 1);
    end
  endtask

  initial begin : main
    test_reset();
    test_single();
    test_gap();
    test_out_of_range();
    test_timeout();
    test_reset_mid_burst();
    test_back_to_back();
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
